// File: rtl/ex_flag_stage_pkg.sv
// ex_flag_stage_pkg: shared widths, opcodes, branch condition codes and flag indices
package ex_flag_stage_pkg;
  localparam int DW = 16;
  localparam int RW = 4;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h2;
  localparam logic [3:0] OP_SLL = 4'h4;
  localparam logic [3:0] OP_SRA = 4'h5;
  localparam logic [3:0] OP_ROR = 4'h6;
  typedef enum logic [2:0] {
    CC_NE  = 3'b000,
    CC_EQ  = 3'b001,
    CC_GT  = 3'b010,
    CC_LT  = 3'b011,
    CC_GE  = 3'b100,
    CC_LE  = 3'b101,
    CC_OV  = 3'b110,
    CC_UNC = 3'b111
  } ccc_e;
  function automatic logic [2:0] flag_mask(logic [3:0] op);
    logic [2:0] z_only;
    z_only = 3'b000;
    z_only[FLAG_Z] = 1'b1;
    return (op == OP_ADD || op == OP_SUB) ? 3'b111 :
           (op == OP_XOR || op == OP_SLL || op == OP_SRA || op == OP_ROR) ? z_only : 3'b000;
  endfunction
endpackage

// File: rtl/ex_flag_stage_if.sv
// ex_flag_stage_if: ALU-side input, MEM-side output, flush and branch-query signals of the EX stage
interface ex_flag_stage_if import ex_flag_stage_pkg::*; ();
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_opcode;
  logic [DW-1:0] in_result;
  logic          in_ovfl;
  logic          in_zero;
  logic          in_sign;
  logic [RW-1:0] in_rd;
  logic          in_we;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_result;
  logic [RW-1:0] out_rd;
  logic          out_we;
  logic [2:0]    flags_nzv;
  logic [2:0]    br_ccc;
  logic          br_taken;
  modport slave (
    input  in_valid, in_opcode, in_result, in_ovfl, in_zero, in_sign, in_rd, in_we,
    input  flush, out_ready, br_ccc,
    output in_ready, out_valid, out_result, out_rd, out_we, flags_nzv, br_taken
  );
  modport master (
    output in_valid, in_opcode, in_result, in_ovfl, in_zero, in_sign, in_rd, in_we,
    output flush, out_ready, br_ccc,
    input  in_ready, out_valid, out_result, out_rd, out_we, flags_nzv, br_taken
  );
endinterface

// File: rtl/ex_flag_stage_flag_cond_eval.sv
// flag_cond_eval: combinational branch condition evaluation against {N,Z,V} flags
module flag_cond_eval import ex_flag_stage_pkg::*; (
  input  logic [2:0] flags_nzv,
  input  ccc_e       ccc,
  output logic       taken
);
  logic n, z, v;
  always_comb begin
    n = flags_nzv[FLAG_N];
    z = flags_nzv[FLAG_Z];
    v = flags_nzv[FLAG_V];
    taken = (ccc == CC_NE) ? !z :
            (ccc == CC_EQ) ? z :
            (ccc == CC_GT) ? (!z & !n) :
            (ccc == CC_LT) ? n :
            (ccc == CC_GE) ? (z | (!z & !n)) :
            (ccc == CC_LE) ? (n | z) :
            (ccc == CC_OV) ? v : 1'b1;
  end
endmodule

// File: rtl/ex_flag_stage.sv
// ex_flag_stage: EX->MEM pipeline register with handshake, flush and architectural N/Z/V flags
module ex_flag_stage import ex_flag_stage_pkg::*; (
  input logic           clk,
  input logic           rst,
  ex_flag_stage_if.slave bus
);
  logic          out_valid_q, out_valid_d;
  logic          out_we_q, out_we_d;
  logic [DW-1:0] out_result_q, out_result_d;
  logic [RW-1:0] out_rd_q, out_rd_d;
  logic [2:0]    flags_q, flags_d;
  logic [2:0]    mask, alu_nzv;
  logic          in_ready, accept, drain;
  always_comb begin
    in_ready = (!out_valid_q | bus.out_ready) & !bus.flush;
    accept = bus.in_valid & in_ready;
    drain = out_valid_q & bus.out_ready;
    mask = flag_mask(bus.in_opcode);
    alu_nzv = 3'b000;
    alu_nzv[FLAG_N] = bus.in_sign;
    alu_nzv[FLAG_Z] = bus.in_zero;
    alu_nzv[FLAG_V] = bus.in_ovfl;
    flags_d = accept ? ((flags_q & ~mask) | (alu_nzv & mask)) : flags_q;
    out_valid_d = !bus.flush & (accept | (out_valid_q & !drain));
    out_we_d = bus.flush ? 1'b0 : accept ? bus.in_we : drain ? 1'b0 : out_we_q;
    out_result_d = accept ? bus.in_result : out_result_q;
    out_rd_d = accept ? bus.in_rd : out_rd_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_we_q <= 1'b0;
      out_result_q <= '0;
      out_rd_q <= '0;
      flags_q <= 3'b000;
    end else begin
      out_valid_q <= out_valid_d;
      out_we_q <= out_we_d;
      out_result_q <= out_result_d;
      out_rd_q <= out_rd_d;
      flags_q <= flags_d;
    end
  end
  assign bus.in_ready = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_we = out_we_q;
  assign bus.out_result = out_result_q;
  assign bus.out_rd = out_rd_q;
  assign bus.flags_nzv = flags_q;
  flag_cond_eval u_cond (
    .flags_nzv(flags_q),
    .ccc      (ccc_e'(bus.br_ccc)),
    .taken    (bus.br_taken)
  );
endmodule

// File: tb/tb_ex_flag_stage.sv
// tb_ex_flag_stage: scoreboard-driven directed bench for the EX flag stage
module tb_ex_flag_stage;
  import ex_flag_stage_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  ex_flag_stage_if bus ();
  ex_flag_stage dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] result;
    logic [3:0]  rd;
    logic        we;
  } entry_t;
  entry_t sb[$];
  logic m_valid;
  logic [2:0] m_flags;
  wire m_ready = (!m_valid | bus.out_ready) & !bus.flush;

  function automatic logic [2:0] model_flags(logic [2:0] f, logic [3:0] op, logic s, logic z, logic v);
    case (op)
      4'h0, 4'h1: return {s, z, v};
      4'h2, 4'h4, 4'h5, 4'h6: return {f[2], z, f[0]};
      default: return f;
    endcase
  endfunction

  function automatic logic model_taken(logic [2:0] f, logic [2:0] c);
    case (c)
      3'd0: return !f[1];
      3'd1: return f[1];
      3'd2: return !f[1] & !f[2];
      3'd3: return f[2];
      3'd4: return f[1] | (!f[1] & !f[2]);
      3'd5: return f[2] | f[1];
      3'd6: return f[0];
      default: return 1'b1;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_flags <= 3'b000;
      sb.delete();
    end else if (bus.in_valid && m_ready) begin
      sb.push_back({bus.in_result, bus.in_rd, bus.in_we});
      m_valid <= 1'b1;
      m_flags <= model_flags(m_flags, bus.in_opcode, bus.in_sign, bus.in_zero, bus.in_ovfl);
    end else if (bus.flush || bus.out_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (bus.out_valid !== m_valid) begin errors++; $display("FAIL mon_out_valid: got %b want %b", bus.out_valid, m_valid); end
      checks++;
      if (bus.in_ready !== m_ready) begin errors++; $display("FAIL mon_in_ready: got %b want %b", bus.in_ready, m_ready); end
      checks++;
      if (bus.flags_nzv !== m_flags) begin errors++; $display("FAIL mon_flags: got %b want %b", bus.flags_nzv, m_flags); end
      checks++;
      if (bus.br_taken !== model_taken(m_flags, bus.br_ccc)) begin
        errors++; $display("FAIL mon_br_taken: ccc %b got %b want %b", bus.br_ccc, bus.br_taken, model_taken(m_flags, bus.br_ccc));
      end
      if (!m_valid) begin
        checks++;
        if (bus.out_we !== 1'b0) begin errors++; $display("FAIL mon_we_idle: got %b want 0", bus.out_we); end
      end
      if (m_valid && (bus.out_ready || bus.flush)) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL sb_empty: got 0 entries want >=1");
        end else if (bus.out_ready) begin
          entry_t e;
          e = sb.pop_front();
          if ({bus.out_result, bus.out_rd, bus.out_we} !== e) begin
            errors++; $display("FAIL sb_entry: got %h/%h/%b want %h/%h/%b", bus.out_result, bus.out_rd, bus.out_we, e.result, e.rd, e.we);
          end
        end else begin
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [3:0] op, logic [15:0] res, logic ovfl, logic zero, logic sign, logic [3:0] rd, logic we);
    bus.in_valid = v; bus.in_opcode = op; bus.in_result = res;
    bus.in_ovfl = ovfl; bus.in_zero = zero; bus.in_sign = sign;
    bus.in_rd = rd; bus.in_we = we;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #2;
    checks++;
    if ({bus.out_valid, bus.out_result, bus.out_rd, bus.out_we, bus.flags_nzv} !== 25'h0) begin
      errors++; $display("FAIL reset_state: got v%b r%h rd%h we%b f%b want all zero", bus.out_valid, bus.out_result, bus.out_rd, bus.out_we, bus.flags_nzv);
    end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_sub_zero();
    bus.br_ccc = 3'b001;
    #1;
    checks++;
    if (bus.br_taken !== 1'b0) begin errors++; $display("FAIL eq_before: got %b want 0", bus.br_taken); end
    drive(1'b1, 4'h1, 16'h0000, 1'b0, 1'b1, 1'b0, 4'h3, 1'b1);
    step();
    idle();
    checks++;
    if ({bus.flags_nzv, bus.out_valid, bus.out_result, bus.out_rd, bus.br_taken} !== {3'b010, 1'b1, 16'h0000, 4'h3, 1'b1}) begin
      errors++; $display("FAIL sub_zero: got f%b v%b r%h rd%h br%b want f010 v1 r0000 rd3 br1", bus.flags_nzv, bus.out_valid, bus.out_result, bus.out_rd, bus.br_taken);
    end
    step();
  endtask

  task automatic test_sub_sat();
    drive(1'b1, 4'h1, 16'h7FFF, 1'b1, 1'b0, 1'b0, 4'h4, 1'b1);
    step();
    idle();
    checks++;
    if (bus.flags_nzv !== 3'b001) begin errors++; $display("FAIL sat_flags: got %b want 001", bus.flags_nzv); end
    bus.br_ccc = 3'b110;
    #1;
    checks++;
    if (bus.br_taken !== 1'b1) begin errors++; $display("FAIL sat_ov: got %b want 1", bus.br_taken); end
    bus.br_ccc = 3'b011;
    #1;
    checks++;
    if (bus.br_taken !== 1'b0) begin errors++; $display("FAIL sat_lt: got %b want 0", bus.br_taken); end
    step();
  endtask

  task automatic test_xor();
    drive(1'b1, 4'h1, 16'h0000, 1'b1, 1'b1, 1'b0, 4'h1, 1'b1);
    step();
    checks++;
    if (bus.flags_nzv !== 3'b011) begin errors++; $display("FAIL xor_pre: got %b want 011", bus.flags_nzv); end
    drive(1'b1, 4'h2, 16'h8000, 1'b0, 1'b0, 1'b1, 4'h2, 1'b1);
    step();
    idle();
    checks++;
    if (bus.flags_nzv !== 3'b001) begin errors++; $display("FAIL xor_flags: got %b want 001", bus.flags_nzv); end
    step();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(1'b1, 4'h0, 16'h1234, 1'b0, 1'b0, 1'b0, 4'h5, 1'b1);
    step();
    drive(1'b1, 4'h0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 4'h6, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, bus.in_ready); end
      step();
      checks++;
      if ({bus.out_result, bus.out_rd, bus.out_we, bus.flags_nzv} !== {16'h1234, 4'h5, 1'b1, 3'b000}) begin
        errors++; $display("FAIL bp_hold[%0d]: got r%h rd%h we%b f%b want r1234 rd5 we1 f000", i, bus.out_result, bus.out_rd, bus.out_we, bus.flags_nzv);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %b want 1", bus.in_ready); end
    step();
    idle();
    checks++;
    if ({bus.out_valid, bus.out_result, bus.out_we, bus.flags_nzv} !== {1'b1, 16'hFFFF, 1'b0, 3'b101}) begin
      errors++; $display("FAIL bp_b2b: got v%b r%h we%b f%b want v1 rFFFF we0 f101", bus.out_valid, bus.out_result, bus.out_we, bus.flags_nzv);
    end
    step();
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    drive(1'b1, 4'h0, 16'h00AA, 1'b0, 1'b0, 1'b0, 4'h7, 1'b1);
    step();
    drive(1'b1, 4'h0, 16'h5555, 1'b1, 1'b0, 1'b1, 4'h8, 1'b1);
    bus.flush = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", bus.in_ready); end
    step();
    bus.flush = 1'b0;
    idle();
    checks++;
    if ({bus.out_valid, bus.out_we, bus.flags_nzv} !== {1'b0, 1'b0, 3'b000}) begin
      errors++; $display("FAIL flush_kill: got v%b we%b f%b want v0 we0 f000", bus.out_valid, bus.out_we, bus.flags_nzv);
    end
    bus.out_ready = 1'b1;
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_accept: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    drive(1'b1, 4'h0, 16'h0100, 1'b0, 1'b0, 1'b0, 4'h1, 1'b1);
    step();
    checks++;
    if ({bus.out_valid, bus.out_result} !== {1'b1, 16'h0100}) begin errors++; $display("FAIL b2b_add: got v%b r%h want v1 r0100", bus.out_valid, bus.out_result); end
    drive(1'b1, 4'h1, 16'hFF00, 1'b0, 1'b0, 1'b1, 4'h2, 1'b1);
    step();
    checks++;
    if ({bus.out_valid, bus.out_result, bus.flags_nzv} !== {1'b1, 16'hFF00, 3'b100}) begin
      errors++; $display("FAIL b2b_sub: got v%b r%h f%b want v1 rFF00 f100", bus.out_valid, bus.out_result, bus.flags_nzv);
    end
    drive(1'b1, 4'h3, 16'h0000, 1'b1, 1'b1, 1'b0, 4'h9, 1'b1);
    step();
    idle();
    checks++;
    if ({bus.out_valid, bus.out_result, bus.out_rd, bus.flags_nzv} !== {1'b1, 16'h0000, 4'h9, 3'b100}) begin
      errors++; $display("FAIL b2b_red: got v%b r%h rd%h f%b want v1 r0000 rd9 f100", bus.out_valid, bus.out_result, bus.out_rd, bus.flags_nzv);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    drive(1'b1, 4'h0, 16'hBEEF, 1'b1, 1'b0, 1'b1, 4'hA, 1'b1);
    step();
    idle();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.out_valid, bus.out_we, bus.flags_nzv, bus.out_result} !== 21'h0) begin
      errors++; $display("FAIL mid_reset: got v%b we%b f%b r%h want all zero", bus.out_valid, bus.out_we, bus.flags_nzv, bus.out_result);
    end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got %b want 1", bus.in_ready); end
    bus.out_ready = 1'b1;
  endtask

  initial begin
    idle();
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    bus.br_ccc = 3'b000;
    test_reset();
    test_sub_zero();
    test_sub_sat();
    test_xor();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    repeat (3) step();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d entries want 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
